uart_rx_fifo: RTL and testbench

- Downstream consumer of the uart receive side.
- Watches rx_empty and pulses uld_rx_data to unload each received byte. Captures rx_data into an internal FIFO and presents bytes to the FPGA-side logic over a valid/ready stream.
- Removes the uart's "unload before the next byte overwrites it" timing burden from the user logic.
- Tracks overflow when the FIFO cannot accept a byte.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 89 ++++++++
 rtl/uart_rx_fifo.sv | 124 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart receive-side FIFO slice.
//   rx_state_e     : states of the unload FSM in uart_rx_fifo
//   DEFAULT_DATA_W : default byte width, matches the uart rx_data bus
//   clog2()        : ceiling log2, used to size pointers and occupancy counts
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    UNLOAD    = 3'd1,
    CAPTURE   = 3'd2,
    DISCARD   = 3'd3,
    CAPTURE_D = 3'd4
  } rx_state_e;

  localparam int DEFAULT_DATA_W = 8;

  // Ceiling log2 as a constant function so port widths can be derived from
  // parameters. clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
  function automatic int clog2(input int unsigned value);
    int unsigned remaining;
    int          bits;
    remaining = (value > 0) ? value - 1 : 0;
    bits      = 0;
    for (int i = 0; i < 32; i++) begin
      if (remaining != 0) begin
        bits++;
        remaining = remaining >> 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO: rd_data always shows the head
// entry while empty is low, and advances on the cycle after a read.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   wr_en, wr_data    : push wr_data when wr_en and not full
//   rd_en, rd_data    : pop the head when rd_en and not empty
//   count             : current occupancy, 0..DEPTH
//   full, empty       : count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = 16,
  localparam int PTR_W  = clog2(DEPTH),
  localparam int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_wr;
  logic              do_rd;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Requests against a full or empty FIFO are ignored, so the count can
  // never wrap in either direction.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Pointers are exactly PTR_W bits wide; DEPTH is a power of two so they
  // wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the write is still blocked while reset_n is low
  // so a reset never leaves a half-committed entry behind.
  always_ff @(posedge clk) begin
    if (reset_n && do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Unloads received bytes from the uart as soon as they arrive and buffers
// them in a FIFO, presenting them to user logic as a valid/ready stream.
// Ports:
//   clk, reset_n     : clock (also the uart rxclk), synchronous active-low reset
//   rx_empty         : from uart, 0 while a byte is waiting
//   rx_data          : from uart, valid the cycle after uld_rx_data
//   uld_rx_data      : to uart, registered one-cycle unload pulse
//   m_data, m_valid  : head of FIFO (fall-through) and non-empty flag
//   m_ready          : consumer pops when m_valid && m_ready
//   count            : FIFO occupancy
//   overflow         : sticky, a byte was unloaded and dropped while full
//   clr_overflow     : clears overflow (a simultaneous drop wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W         = DEFAULT_DATA_W,
  parameter  int DEPTH          = 16,
  parameter  bit DROP_WHEN_FULL = 1'b1,
  localparam int CNT_W          = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] rx_data,
  output logic              uld_rx_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              clr_overflow
);

  rx_state_e state_q, state_d;
  logic      uld_q, uld_d;
  logic      overflow_q, overflow_d;
  logic      fifo_wr;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;

  assign uld_rx_data = uld_q;
  assign overflow    = overflow_q;
  assign m_valid     = !fifo_empty;
  assign pop         = m_valid && m_ready;

  // Unload FSM. A slot is effectively reserved the moment UNLOAD is chosen:
  // nothing else writes the FIFO until CAPTURE completes and pops can only
  // free space, so the captured byte always fits.
  always_comb begin
    state_d    = state_q;
    fifo_wr    = 1'b0;
    overflow_d = overflow_q;
    if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          if (!fifo_full) begin
            state_d = UNLOAD;
          end else if (DROP_WHEN_FULL) begin
            state_d = DISCARD;
          end
        end
      end
      UNLOAD: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (rx_empty) begin
          fifo_wr = 1'b1;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        overflow_d = 1'b1;
        state_d    = CAPTURE_D;
      end
      CAPTURE_D: begin
        if (rx_empty) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The pulse is registered alongside the state, so it is high exactly
    // for the single cycle spent in UNLOAD or DISCARD.
    uld_d = (state_d == UNLOAD) || (state_d == DISCARD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      uld_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      uld_q      <= uld_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr),
    .wr_data (rx_data),
    .rd_en   (pop),
    .rd_data (m_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Two instances with DEPTH=4: dutA drops bytes arriving while full, dutB
// leaves them waiting in the uart. A behavioural uart feeds each instance.
// For dutA the expected byte stream is kept as a queue: each unloaded byte is
// appended unless the FIFO was full when it was unloaded, and a separate
// monitor pops and compares on every accepted transfer.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              resetN;
  logic              rxEmptyA, uldA, mValidA, mReadyA, ovfA, clrOvfA;
  logic [DATA_W-1:0] rxDataA, mDataA;
  logic [CNT_W-1:0]  cntA;
  logic              rxEmptyB, uldB, mValidB, mReadyB, ovfB, clrOvfB;
  logic [DATA_W-1:0] rxDataB, mDataB;
  logic [CNT_W-1:0]  cntB;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_WHEN_FULL(1'b1)) dutA (
    .clk(clk), .reset_n(resetN), .rx_empty(rxEmptyA), .rx_data(rxDataA),
    .uld_rx_data(uldA), .m_data(mDataA), .m_valid(mValidA), .m_ready(mReadyA),
    .count(cntA), .overflow(ovfA), .clr_overflow(clrOvfA)
  );

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DROP_WHEN_FULL(1'b0)) dutB (
    .clk(clk), .reset_n(resetN), .rx_empty(rxEmptyB), .rx_data(rxDataB),
    .uld_rx_data(uldB), .m_data(mDataB), .m_valid(mValidB), .m_ready(mReadyB),
    .count(cntB), .overflow(ovfB), .clr_overflow(clrOvfB)
  );

  int checks   = 0;
  int failures = 0;
  bit checkOn  = 1'b0;

  logic [DATA_W-1:0] srcQA[$];
  logic [DATA_W-1:0] modQA[$];
  logic [DATA_W-1:0] srcQB[$];
  logic [DATA_W-1:0] holdA, holdB;
  int gapA = 0, gapB = 0;
  int lastSizeA = 0;
  int uldPulsesA = 0, uldPulsesB = 0, popsA = 0;
  int arrivePct = 100;
  bit expOvfA = 1'b0, uldPrevA = 1'b0, uldPrevB = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timeout waiting, actual=expired required=done at %0t", name, $time);
  endtask

  // One negedge of both behavioural uarts plus the dutA expectation model.
  // The FIFO occupancy a decision sees is the model size recorded on the
  // previous negedge (before that cycle's pop).
  task automatic applyStimulus(input bit clrA);
    bit discard;
    discard = 1'b0;
    if (checkOn) checkOutput("overflowA", ovfA, expOvfA);
    if (uldA === 1'b1) begin
      if (checkOn) checkOutput("uldA_spacing", uldPrevA, 1'b0);
      uldPulsesA++;
      if (lastSizeA >= DEPTH) begin
        discard = 1'b1;
        expOvfA = 1'b1;
      end else begin
        modQA.push_back(holdA);
      end
      rxDataA  = holdA;
      rxEmptyA = 1'b1;
      gapA     = 1 + $urandom_range(0, 2);
    end else if (gapA > 0) begin
      gapA--;
    end else if (rxEmptyA && srcQA.size() > 0 && $urandom_range(0, 99) < arrivePct) begin
      holdA    = srcQA.pop_front();
      rxEmptyA = 1'b0;
      rxDataA  = 8'($urandom);
    end
    uldPrevA  = (uldA === 1'b1);
    lastSizeA = modQA.size();
    clrOvfA   = clrA;
    if (clrA && !discard) expOvfA = 1'b0;

    if (uldB === 1'b1) begin
      if (checkOn) checkOutput("uldB_spacing", uldPrevB, 1'b0);
      uldPulsesB++;
      rxDataB  = holdB;
      rxEmptyB = 1'b1;
      gapB     = 1 + $urandom_range(0, 2);
    end else if (gapB > 0) begin
      gapB--;
    end else if (rxEmptyB && srcQB.size() > 0) begin
      holdB    = srcQB.pop_front();
      rxEmptyB = 1'b0;
      rxDataB  = 8'($urandom);
    end
    uldPrevB = (uldB === 1'b1);
  endtask

  task automatic tick(input bit clrA);
    @(negedge clk);
    applyStimulus(clrA);
  endtask

  task automatic waitQuietA(input string name);
    int n;
    n = 0;
    while ((srcQA.size() != 0 || rxEmptyA !== 1'b1 || gapA != 0) && n < 2000) begin
      tick(1'b0);
      n++;
    end
    if (n >= 2000) reportTimeout(name);
    repeat (4) tick(1'b0);
  endtask

  task automatic waitUnloadA(input string name);
    int p0, n;
    p0 = uldPulsesA;
    n  = 0;
    while (uldPulsesA == p0 && n < 100) begin
      tick(1'b0);
      n++;
    end
    if (n >= 100) reportTimeout(name);
  endtask

  // Scoreboard monitor for dutA: runs just after each negedge so the
  // stimulus for the cycle is settled, and compares every accepted byte.
  always begin
    logic [DATA_W-1:0] expByte;
    @(negedge clk);
    #1;
    if (resetN === 1'b1 && mValidA === 1'b1 && mReadyA === 1'b1) begin
      popsA++;
      if (modQA.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL popA_unexpected actual=%0h required=no_byte at %0t", mDataA, $time);
      end else begin
        expByte = modQA.pop_front();
        checkOutput("popA_data", mDataA, expByte);
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, n;
    logic [DATA_W-1:0] expSeq[4];

    resetN   = 1'b0;
    rxEmptyA = 1'b1; rxDataA = '0; mReadyA = 1'b0; clrOvfA = 1'b0;
    rxEmptyB = 1'b1; rxDataB = '0; mReadyB = 1'b0; clrOvfB = 1'b0;
    holdA = '0; holdB = '0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    tick(1'b0);
    checkOn = 1'b1;

    $display("[TB] reset state");
    checkOutput("reset_cntA", cntA, 0);
    checkOutput("reset_validA", mValidA, 0);
    checkOutput("reset_ovfA", ovfA, 0);
    checkOutput("reset_uldA", uldA, 0);
    checkOutput("reset_cntB", cntB, 0);
    checkOutput("reset_validB", mValidB, 0);

    $display("[TB] single byte");
    mReadyA = 1'b1;
    p0 = popsA;
    n  = uldPulsesA;
    srcQA.push_back(8'h55);
    waitQuietA("single");
    checkOutput("single_uld_pulses", uldPulsesA - n, 1);
    checkOutput("single_pops", popsA - p0, 1);
    checkOutput("single_cnt", cntA, 0);
    checkOutput("single_ovf", ovfA, 0);

    $display("[TB] burst of three, consumer stalled");
    mReadyA = 1'b0;
    srcQA.push_back(8'h55); srcQA.push_back(8'h41); srcQA.push_back(8'h7D);
    waitQuietA("burst");
    checkOutput("burst_cnt", cntA, 3);
    checkOutput("burst_head", mDataA, 8'h55);
    mReadyA = 1'b1;
    tick(1'b0);
    checkOutput("burst_valid1", mValidA, 1);
    checkOutput("burst_data1", mDataA, 8'h41);
    tick(1'b0);
    checkOutput("burst_valid2", mValidA, 1);
    checkOutput("burst_data2", mDataA, 8'h7D);
    tick(1'b0);
    checkOutput("burst_valid_end", mValidA, 0);
    checkOutput("burst_cnt_end", cntA, 0);

    $display("[TB] overfill with drop");
    mReadyA = 1'b0;
    for (int i = 1; i <= 5; i++) srcQA.push_back(8'(i));
    waitQuietA("drop_fill");
    checkOutput("drop_cnt", cntA, 4);
    checkOutput("drop_ovf", ovfA, 1);
    tick(1'b1);
    tick(1'b0);
    checkOutput("drop_ovf_cleared", ovfA, 0);
    for (int i = 0; i < 4; i++) expSeq[i] = 8'(i + 1);
    checkOutput("drop_valid0", mValidA, 1);
    checkOutput("drop_data0", mDataA, expSeq[0]);
    mReadyA = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick(1'b0);
      checkOutput("drop_data", mDataA, expSeq[i]);
    end
    tick(1'b0);
    checkOutput("drop_valid_end", mValidA, 0);

    $display("[TB] simultaneous push and pop");
    mReadyA = 1'b0;
    srcQA.push_back(8'hAA);
    waitQuietA("simul_fill");
    checkOutput("simul_cnt1", cntA, 1);
    srcQA.push_back(8'hBB);
    waitUnloadA("simul_unload");
    tick(1'b0);
    checkOutput("simul_head_aa", mDataA, 8'hAA);
    mReadyA = 1'b1;
    tick(1'b0);
    checkOutput("simul_cnt", cntA, 1);
    checkOutput("simul_valid", mValidA, 1);
    checkOutput("simul_data", mDataA, 8'hBB);
    tick(1'b0);
    checkOutput("simul_cnt_end", cntA, 0);
    checkOutput("simul_valid_end", mValidA, 0);

    $display("[TB] reset during capture");
    mReadyA = 1'b0;
    srcQA.push_back(8'h11); srcQA.push_back(8'h22);
    waitQuietA("rst_fill");
    checkOutput("rst_cnt_before", cntA, 2);
    srcQA.push_back(8'h33);
    waitUnloadA("rst_unload");
    tick(1'b0);
    resetN = 1'b0;
    modQA.delete();
    expOvfA   = 1'b0;
    lastSizeA = 0;
    tick(1'b0);
    resetN = 1'b1;
    checkOutput("rst_valid", mValidA, 0);
    checkOutput("rst_cnt", cntA, 0);
    checkOutput("rst_ovf", ovfA, 0);
    mReadyA = 1'b1;
    p0 = popsA;
    srcQA.push_back(8'h3C);
    waitQuietA("rst_after");
    checkOutput("rst_after_pops", popsA - p0, 1);
    checkOutput("rst_after_cnt", cntA, 0);

    $display("[TB] randomized traffic");
    arrivePct = 60;
    foreach (expSeq[s]) begin
      int readyPct;
      if (s == 3) break;
      readyPct = (s == 0) ? 15 : (s == 1) ? 60 : 95;
      for (int i = 0; i < 150; i++) srcQA.push_back(8'($urandom));
      n = 0;
      while (srcQA.size() > 0 && n < 20000) begin
        tick($urandom_range(0, 31) == 0);
        mReadyA = ($urandom_range(0, 99) < readyPct);
        n++;
      end
      if (n >= 20000) reportTimeout("random_segment");
    end
    mReadyA = 1'b1;
    waitQuietA("random_quiet");
    n = 0;
    while (modQA.size() > 0 && n < 200) begin
      tick(1'b0);
      n++;
    end
    tick(1'b0);
    checkOutput("random_left", modQA.size(), 0);
    checkOutput("random_cnt", cntA, 0);
    checkOutput("random_valid", mValidA, 0);
    checkOutput("random_ovf", ovfA, expOvfA);

    $display("[TB] overfill without drop");
    mReadyB = 1'b0;
    for (int i = 1; i <= 5; i++) srcQB.push_back(8'(i));
    repeat (80) tick(1'b0);
    checkOutput("hold_cnt", cntB, 4);
    checkOutput("hold_ovf", ovfB, 0);
    checkOutput("hold_rx_empty", rxEmptyB, 0);
    checkOutput("hold_uld_pulses", uldPulsesB, 4);
    repeat (10) tick(1'b0);
    checkOutput("hold_uld_still", uldPulsesB, 4);
    checkOutput("hold_head", mDataB, 8'h01);
    mReadyB = 1'b1;
    tick(1'b0);
    mReadyB = 1'b0;
    repeat (15) tick(1'b0);
    checkOutput("hold_uld_after_pop", uldPulsesB, 5);
    checkOutput("hold_cnt_after_pop", cntB, 4);
    checkOutput("hold_rx_empty_after", rxEmptyB, 1);
    for (int i = 0; i < 4; i++) expSeq[i] = 8'(i + 2);
    checkOutput("hold_valid0", mValidB, 1);
    checkOutput("hold_data0", mDataB, expSeq[0]);
    mReadyB = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick(1'b0);
      checkOutput("hold_data", mDataB, expSeq[i]);
    end
    tick(1'b0);
    checkOutput("hold_valid_end", mValidB, 0);
    checkOutput("hold_cnt_end", cntB, 0);
    checkOutput("hold_ovf_end", ovfB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
